// File: rtl/cnt_step_if.sv
// Sample bus from the up/down counter to its step checker: one valid-qualified
// count value plus the direction that was in effect for it.
interface cnt_step_if #(
   parameter int WIDTH = 10
);
   logic             cnt_valid;
   logic [WIDTH-1:0] cnt;
   logic             mode;

   modport master (
      output cnt_valid,
      output cnt,
      output mode
   );

   modport slave (
      input cnt_valid,
      input cnt,
      input mode
   );
endinterface

// File: rtl/cnt_step_checker.sv
// Consumer-side checker for the up/down counter: verifies each sample is one step
// from the previous one, reports and counts wraps, and latches a fault on repeated errors.
module cnt_step_checker #(
   parameter int WIDTH     = 10,
   parameter int WRAP_W    = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   cnt_step_if.slave         smp,
   output logic              wrap_up,
   output logic              wrap_dn,
   output logic              step_err,
   output logic              fault,
   output logic              tracking,
   output logic [WRAP_W-1:0] wrap_total
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TRACK = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [WIDTH-1:0]  CNT_ONE  = 1;
   localparam logic [WIDTH-1:0]  CNT_MAX  = '1;
   localparam logic [WRAP_W-1:0] WRAP_ONE = 1;
   localparam logic [3:0]        RUN_ONE  = 4'd1;
   localparam logic [3:0]        RUN_LIM  = 4'(ERR_LIMIT);

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    prev_cnt_q, prev_cnt_d;
   logic                prev_mode_q, prev_mode_d;
   logic [3:0]          err_run_q, err_run_d;
   logic                wrap_up_q, wrap_up_d;
   logic                wrap_dn_q, wrap_dn_d;
   logic                step_err_q, step_err_d;
   logic                fault_q, fault_d;
   logic                tracking_q, tracking_d;
   logic [WRAP_W-1:0]   wrap_total_q, wrap_total_d;

   logic [WIDTH-1:0]    exp_cnt;
   logic                is_wrap_up;
   logic                is_wrap_dn;

   // Wrap counter holds at all-ones rather than rolling over.
   function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
      sat_inc = (v == '1) ? v : v + WRAP_ONE;
   endfunction

   assign exp_cnt    = prev_mode_q ? prev_cnt_q + CNT_ONE : prev_cnt_q - CNT_ONE;
   assign is_wrap_up = prev_mode_q  && (prev_cnt_q == CNT_MAX) && (smp.cnt == '0);
   assign is_wrap_dn = !prev_mode_q && (prev_cnt_q == '0)      && (smp.cnt == CNT_MAX);

   always_comb begin
      state_d      = state_q;
      prev_cnt_d   = prev_cnt_q;
      prev_mode_d  = prev_mode_q;
      err_run_d    = err_run_q;
      wrap_total_d = wrap_total_q;
      wrap_up_d    = 1'b0;
      wrap_dn_d    = 1'b0;
      step_err_d   = 1'b0;

      if (clr) begin
         state_d      = ST_IDLE;
         prev_cnt_d   = '0;
         prev_mode_d  = 1'b0;
         err_run_d    = '0;
         wrap_total_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (smp.cnt_valid) begin
                  prev_cnt_d  = smp.cnt;
                  prev_mode_d = smp.mode;
                  state_d     = ST_TRACK;
               end
            end
            ST_TRACK: begin
               if (smp.cnt_valid) begin
                  // A mismatch still adopts the new sample so one glitch is not re-reported forever.
                  prev_cnt_d  = smp.cnt;
                  prev_mode_d = smp.mode;
                  if (smp.cnt == exp_cnt) begin
                     err_run_d = '0;
                     wrap_up_d = is_wrap_up;
                     wrap_dn_d = is_wrap_dn;
                     if (is_wrap_up || is_wrap_dn) begin
                        wrap_total_d = sat_inc(wrap_total_q);
                     end
                  end else begin
                     step_err_d = 1'b1;
                     err_run_d  = err_run_q + RUN_ONE;
                     if (err_run_d == RUN_LIM) begin
                        state_d = ST_FAULT;
                     end
                  end
               end
            end
            ST_FAULT: begin
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      fault_d    = (state_d == ST_FAULT);
      tracking_d = (state_d == ST_TRACK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         prev_cnt_q   <= '0;
         prev_mode_q  <= 1'b0;
         err_run_q    <= '0;
         wrap_up_q    <= 1'b0;
         wrap_dn_q    <= 1'b0;
         step_err_q   <= 1'b0;
         fault_q      <= 1'b0;
         tracking_q   <= 1'b0;
         wrap_total_q <= '0;
      end else begin
         state_q      <= state_d;
         prev_cnt_q   <= prev_cnt_d;
         prev_mode_q  <= prev_mode_d;
         err_run_q    <= err_run_d;
         wrap_up_q    <= wrap_up_d;
         wrap_dn_q    <= wrap_dn_d;
         step_err_q   <= step_err_d;
         fault_q      <= fault_d;
         tracking_q   <= tracking_d;
         wrap_total_q <= wrap_total_d;
      end
   end

   assign wrap_up    = wrap_up_q;
   assign wrap_dn    = wrap_dn_q;
   assign step_err   = step_err_q;
   assign fault      = fault_q;
   assign tracking   = tracking_q;
   assign wrap_total = wrap_total_q;

endmodule

// File: tb/tb_cnt_step_checker.sv
// Bench for cnt_step_checker: directed scenarios plus random traffic, all compared
// against a sample-level reference model of the checking rules.
module tb_cnt_step_checker;
   localparam int WIDTH     = 10;
   localparam int WRAP_W    = 8;
   localparam int ERR_LIMIT = 3;
   localparam int MOD       = 1 << WIDTH;
   localparam int WSAT      = (1 << WRAP_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b0;
   logic              wrap_up, wrap_dn, step_err, fault, tracking;
   logic [WRAP_W-1:0] wrap_total;

   cnt_step_if #(.WIDTH(WIDTH)) bus ();

   cnt_step_checker #(.WIDTH(WIDTH), .WRAP_W(WRAP_W), .ERR_LIMIT(ERR_LIMIT)) dut (
      .clk(clk), .rst(rst), .clr(clr), .smp(bus.slave),
      .wrap_up(wrap_up), .wrap_dn(wrap_dn), .step_err(step_err),
      .fault(fault), .tracking(tracking), .wrap_total(wrap_total)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: 0 = waiting for first sample, 1 = tracking, 2 = faulted.
   int m_phase = 0;
   int m_prev  = 0;
   int m_pmode = 0;
   int m_run   = 0;
   int m_wraps = 0;
   logic [WRAP_W+4:0] exp_v;
   logic [WRAP_W+4:0] obs_v;
   assign obs_v = {wrap_up, wrap_dn, step_err, fault, tracking, wrap_total};

   task automatic step(input logic r, input logic cl, input logic v,
                       input int c, input logic m);
      logic wu, wd, se;
      int nxt;
      @(negedge clk);
      rst = r; clr = cl; bus.cnt_valid = v; bus.cnt = WIDTH'(c); bus.mode = m;
      wu = 1'b0; wd = 1'b0; se = 1'b0;
      if (r || cl) begin
         m_phase = 0; m_prev = 0; m_pmode = 0; m_run = 0; m_wraps = 0;
      end else if (v && m_phase == 0) begin
         m_phase = 1; m_prev = c; m_pmode = int'(m);
      end else if (v && m_phase == 1) begin
         nxt = m_pmode ? (m_prev + 1) % MOD : (m_prev + MOD - 1) % MOD;
         if (c == nxt) begin
            m_run = 0;
            wu = (m_pmode == 1 && m_prev == MOD - 1);
            wd = (m_pmode == 0 && m_prev == 0);
            if ((wu || wd) && m_wraps < WSAT) m_wraps++;
         end else begin
            se = 1'b1;
            m_run++;
            if (m_run == ERR_LIMIT) m_phase = 2;
         end
         m_prev = c; m_pmode = int'(m);
      end
      exp_v = {wu, wd, se, (m_phase == 2), (m_phase == 1), WRAP_W'(m_wraps)};
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1, 0, 0, 0, 0);
      checks++;
      if (obs_v !== exp_v || obs_v !== '0) begin
         errors++;
         $display("FAIL reset: got %h want %h", obs_v, exp_v);
      end
      step(0, 0, 0, 0, 0);
      checks++;
      if (obs_v !== '0) begin
         errors++;
         $display("FAIL reset_idle: got %h want 0", obs_v);
      end
   endtask

   task automatic test_track();
      int vals[4]  = '{5, 6, 7, 6};
      logic md[4]  = '{1, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 1, vals[i], md[i]);
         checks++;
         if (obs_v !== exp_v || tracking !== 1'b1 || step_err !== 1'b0) begin
            errors++;
            $display("FAIL track[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
   endtask

   task automatic test_wrap_up();
      int vals[3] = '{1022, 1023, 0};
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, vals[i], 1);
         checks++;
         if (obs_v !== exp_v || wrap_up !== (i == 2)) begin
            errors++;
            $display("FAIL wrap_up[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
      step(0, 0, 0, 0, 1);
      checks++;
      if (obs_v !== exp_v || wrap_up !== 1'b0 || wrap_total !== 8'd1) begin
         errors++;
         $display("FAIL wrap_up_after: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_wrap_dn();
      int vals[3] = '{1, 0, 1023};
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, vals[i], 0);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL wrap_dn[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
      checks++;
      if (wrap_dn !== 1'b1 || wrap_total !== 8'd2) begin
         errors++;
         $display("FAIL wrap_dn_pulse: got dn=%b total=%0d want dn=1 total=2", wrap_dn, wrap_total);
      end
   endtask

   task automatic test_fault();
      int vals[6] = '{100, 105, 200, 300, 301, 302};
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, vals[i], 1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL fault[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
      checks++;
      if (fault !== 1'b1 || tracking !== 1'b0 || wrap_total !== '0) begin
         errors++;
         $display("FAIL fault_state: got fault=%b trk=%b want fault=1 trk=0", fault, tracking);
      end
   endtask

   task automatic test_clr_fault();
      step(0, 1, 1, 50, 1);
      checks++;
      if (obs_v !== exp_v || obs_v !== '0) begin
         errors++;
         $display("FAIL clr_fault: got %h want %h", obs_v, exp_v);
      end
      step(0, 0, 1, 60, 1);
      step(0, 0, 1, 61, 1);
      checks++;
      if (obs_v !== exp_v || step_err !== 1'b0 || tracking !== 1'b1) begin
         errors++;
         $display("FAIL clr_restart: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_wrap_sat();
      step(0, 1, 0, 0, 0);
      step(0, 0, 1, 1023, 1);
      // Each sample alternates 1023(up)->0(down)->1023(up): every step is a wrap.
      for (int i = 0; i < 260; i++) begin
         if (i % 2 == 0) step(0, 0, 1, 0, 0);
         else            step(0, 0, 1, 1023, 1);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL wrap_sat[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
      step(0, 0, 1, 0, 0);
      checks++;
      if (wrap_up !== 1'b1 || wrap_total !== 8'd255) begin
         errors++;
         $display("FAIL wrap_sat_hold: got up=%b total=%0d want up=1 total=255", wrap_up, wrap_total);
      end
   endtask

   task automatic test_mid_rst();
      step(0, 0, 1, 1023, 1);
      step(1, 0, 1, 500, 1);
      checks++;
      if (obs_v !== '0 || obs_v !== exp_v) begin
         errors++;
         $display("FAIL mid_rst: got %h want 0", obs_v);
      end
      step(0, 0, 1, 9, 0);
      step(0, 0, 1, 8, 0);
      checks++;
      if (obs_v !== exp_v || step_err !== 1'b0 || tracking !== 1'b1) begin
         errors++;
         $display("FAIL mid_rst_restart: got %h want %h", obs_v, exp_v);
      end
   endtask

   task automatic test_random();
      int c;
      logic v, m, cl;
      for (int i = 0; i < 3000; i++) begin
         v  = ($urandom_range(0, 3) != 0);
         m  = $urandom_range(0, 1) == 1;
         cl = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 15) == 0) c = $urandom_range(0, MOD - 1);
         else if ($urandom_range(0, 3) == 0) c = ($urandom_range(0, 1) == 1) ? MOD - 1 : 0;
         else c = m_pmode ? (m_prev + 1) % MOD : (m_prev + MOD - 1) % MOD;
         step(0, cl, v, c, m);
         checks++;
         if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL random[%0d]: got %h want %h", i, obs_v, exp_v);
         end
      end
   endtask

   initial begin
      bus.cnt_valid = 1'b0;
      bus.cnt       = '0;
      bus.mode      = 1'b0;
      test_reset();
      test_track();
      test_wrap_up();
      test_wrap_dn();
      test_fault();
      test_clr_fault();
      test_wrap_sat();
      test_mid_rst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
